// File: rtl/vga_timing_if.sv
// Raster timing bundle: run/freeze control into the generator, sync/coordinate/strobe outputs back out.
interface vga_timing_if #(
  parameter int CW = 10
);
  logic          i_enable;
  logic          o_pix_ce;
  logic          o_hsync;
  logic          o_vsync;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic          o_drawing;
  logic          o_line_start;
  logic          o_frame_start;

  modport master (
    input  i_enable,
    output o_pix_ce, o_hsync, o_vsync, o_x, o_y, o_drawing, o_line_start, o_frame_start
  );

  modport slave (
    output i_enable,
    input  o_pix_ce, o_hsync, o_vsync, o_x, o_y, o_drawing, o_line_start, o_frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: divided pixel enable, H/V counters and registered
// sync/active-area/strobe outputs that decode the counter values being loaded on the same edge.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic          i_clk,
  input  logic          i_reset,
  vga_timing_if.master  bus
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if ((64'(H_TOTAL - 1) >= (64'd1 << CW)) || (64'(V_TOTAL - 1) >= (64'd1 << CW))) begin : g_bad_cw
      $error("vga_timing_gen: CW too narrow for H_TOTAL-1 or V_TOTAL-1");
    end
  endgenerate

  function automatic logic in_window(input logic [CW-1:0] c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

  logic [DIV_W-1:0] r_div;
  logic [CW-1:0]    r_h;
  logic [CW-1:0]    r_v;

  logic             r_pix_ce_p1;
  logic             r_hsync_p1;
  logic             r_vsync_p1;
  logic [CW-1:0]    r_x_p1;
  logic [CW-1:0]    r_y_p1;
  logic             r_drawing_p1;
  logic             r_line_start_p1;
  logic             r_frame_start_p1;

  logic             w_pix_ce;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [CW-1:0]    w_h_nxt;
  logic [CW-1:0]    w_v_nxt;
  logic             w_draw_nxt;

  // p0: divider tap and next counter position
  assign w_pix_ce   = bus.i_enable && (r_div == DIV_LAST);
  assign w_h_wrap   = (r_h == H_LAST);
  assign w_v_wrap   = (r_v == V_LAST);
  assign w_h_nxt    = w_h_wrap ? '0 : r_h + 1'b1;
  assign w_v_nxt    = w_h_wrap ? (w_v_wrap ? '0 : r_v + 1'b1) : r_v;
  assign w_draw_nxt = in_window(w_h_nxt, 0, H_ACTIVE) && in_window(w_v_nxt, 0, V_ACTIVE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div <= '0;
      r_h   <= H_LAST;
      r_v   <= V_LAST;
    end else if (bus.i_enable) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      if (w_pix_ce) begin
        r_h <= w_h_nxt;
        r_v <= w_v_nxt;
      end
    end
  end

  // p1: outputs decode the position being loaded, so they line up with the counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pix_ce_p1      <= 1'b0;
      r_hsync_p1       <= ~HS_POL;
      r_vsync_p1       <= ~VS_POL;
      r_x_p1           <= '0;
      r_y_p1           <= '0;
      r_drawing_p1     <= 1'b0;
      r_line_start_p1  <= 1'b0;
      r_frame_start_p1 <= 1'b0;
    end else begin
      r_pix_ce_p1      <= w_pix_ce;
      r_line_start_p1  <= w_pix_ce && w_h_wrap;
      r_frame_start_p1 <= w_pix_ce && w_h_wrap && w_v_wrap;
      if (w_pix_ce) begin
        r_hsync_p1   <= in_window(w_h_nxt, HS_START, HS_END) ? HS_POL : ~HS_POL;
        r_vsync_p1   <= in_window(w_v_nxt, VS_START, VS_END) ? VS_POL : ~VS_POL;
        r_drawing_p1 <= w_draw_nxt;
        r_x_p1       <= w_draw_nxt ? w_h_nxt : '0;
        r_y_p1       <= w_draw_nxt ? w_v_nxt : '0;
      end
    end
  end

  assign bus.o_pix_ce      = r_pix_ce_p1;
  assign bus.o_hsync       = r_hsync_p1;
  assign bus.o_vsync       = r_vsync_p1;
  assign bus.o_x           = r_x_p1;
  assign bus.o_y           = r_y_p1;
  assign bus.o_drawing     = r_drawing_p1;
  assign bus.o_line_start  = r_line_start_p1;
  assign bus.o_frame_start = r_frame_start_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster: pixel-count reference model plus directed period checks.
module tb_vga_timing_gen;

  localparam int CLK_DIV = 2;
  localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
  localparam int CW = 5;
  localparam int HT = HA + HFP + HSW + HBP;   // 14
  localparam int VT = VA + VFP + VSW + VBP;   // 7
  localparam int FT = HT * VT;                // 98 pixels per frame
  localparam int VW = 6 + 2 * CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  vga_timing_if #(.CW(CW)) vif ();

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (vif)
  );

  always #5 clk = ~clk;

  // Reference model: count enabled cycles and pixels since reset; position is pixel index mod frame.
  logic m_live = 1'b0;
  int   m_en_cnt = 0;
  int   m_k = 0;
  logic m_pce = 1'b0, m_ls = 1'b0, m_fs = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_live   <= 1'b1;
      m_en_cnt <= 0;
      m_k      <= 0;
      m_pce    <= 1'b0;
      m_ls     <= 1'b0;
      m_fs     <= 1'b0;
    end else if (vif.i_enable) begin
      m_en_cnt <= m_en_cnt + 1;
      if ((m_en_cnt % CLK_DIV) == CLK_DIV - 1) begin
        m_k   <= m_k + 1;
        m_pce <= 1'b1;
        m_ls  <= ((m_k % FT) % HT) == 0;
        m_fs  <= (m_k % FT) == 0;
      end else begin
        m_pce <= 1'b0;
        m_ls  <= 1'b0;
        m_fs  <= 1'b0;
      end
    end else begin
      m_pce <= 1'b0;
      m_ls  <= 1'b0;
      m_fs  <= 1'b0;
    end
  end

  function automatic logic [VW-1:0] model_vec();
    int q, h, v;
    logic hs, vs, dr;
    logic [CW-1:0] x, y;
    if (m_k == 0) begin
      hs = ~HS_POL; vs = ~VS_POL; dr = 1'b0; x = '0; y = '0;
    end else begin
      q  = (m_k - 1) % FT;
      h  = q % HT;
      v  = q / HT;
      dr = (h < HA) && (v < VA);
      x  = dr ? CW'(h) : '0;
      y  = dr ? CW'(v) : '0;
      hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_POL : ~HS_POL;
      vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_POL : ~VS_POL;
    end
    return {m_pce, hs, vs, dr, m_ls, m_fs, x, y};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {vif.o_pix_ce, vif.o_hsync, vif.o_vsync, vif.o_drawing,
            vif.o_line_start, vif.o_frame_start, vif.o_x, vif.o_y};
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual{pce,hs,vs,dr,ls,fs,x,y}=%b required=%b",
                 $time, dut_vec(), model_vec());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Counts clocks up to and including the next frame_start, with per-signal tallies over the window.
  task automatic wait_fs(output int n, output int nd, output int nhs, output int nvs, output int nls);
    n = 0; nd = 0; nhs = 0; nvs = 0; nls = 0;
    do begin
      @(negedge clk);
      n++;
      nd  += int'(vif.o_drawing);
      nhs += int'(vif.o_hsync == HS_POL);
      nvs += int'(vif.o_vsync == VS_POL);
      nls += int'(vif.o_line_start);
    end while (!vif.o_frame_start && n < 2000);
    if (!vif.o_frame_start) chk("frame_start_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int n, nd, nhs, nvs, nls;
    vif.i_enable = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_vec", 32'(dut_vec()), 32'({1'b0, ~HS_POL, ~VS_POL, 1'b0, 1'b0, 1'b0, 10'd0}));
    rst = 1'b0;

    wait_fs(n, nd, nhs, nvs, nls);
    chk("first_fs_latency", 32'(n), 32'd2);
    chk("first_fs_line_start", 32'(vif.o_line_start), 32'd1);
    chk("first_fs_drawing", 32'(vif.o_drawing), 32'd1);
    chk("first_fs_xy", 32'({vif.o_x, vif.o_y}), 32'd0);
    chk("first_fs_vsync_inactive", 32'(vif.o_vsync), 32'd1);

    wait_fs(n, nd, nhs, nvs, nls);
    chk("frame_period", 32'(n), 32'd196);
    chk("drawing_clocks", 32'(nd), 32'd64);
    chk("hsync_active_clocks", 32'(nhs), 32'd28);
    chk("vsync_active_clocks", 32'(nvs), 32'd28);
    chk("line_starts_per_frame", 32'(nls), 32'd7);
    chk("wrap_fs_with_ls", 32'({vif.o_frame_start, vif.o_line_start}), 32'd3);

    repeat (10) @(negedge clk);
    vif.i_enable = 1'b0;
    repeat (37) @(negedge clk);
    chk("frozen_strobes", 32'({vif.o_pix_ce, vif.o_line_start, vif.o_frame_start}), 32'd0);
    vif.i_enable = 1'b1;
    wait_fs(n, nd, nhs, nvs, nls);
    chk("frozen_frame_period", 32'(n + 47), 32'd233);

    repeat (61) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midframe_reset_vec", 32'(dut_vec()), 32'({1'b0, ~HS_POL, ~VS_POL, 1'b0, 1'b0, 1'b0, 10'd0}));
    rst = 1'b0;
    wait_fs(n, nd, nhs, nvs, nls);
    chk("post_reset_fs_latency", 32'(n), 32'd2);
    chk("post_reset_ls", 32'(vif.o_line_start), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      vif.i_enable = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    vif.i_enable = 1'b1;
    repeat (400) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
